// File: rtl/mem_multi_bank_clr_if.sv
// Bus bundle for mem_multi_bank_clr: write port, read port and clear control.
// master drives wea/banka/addra/dia, reb/bankb/addrb, clr_req/clr_all/clr_bank;
// slave drives dob/dob_valid and clr_busy/clr_done.
interface mem_multi_bank_clr_if #(
  parameter int DATA_WIDTH = 16,
  parameter int BANK_WIDTH = 2,
  parameter int ADDR_WIDTH = 5
);
  logic                  wea;
  logic [BANK_WIDTH-1:0] banka;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dia;
  logic                  reb;
  logic [BANK_WIDTH-1:0] bankb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] dob;
  logic                  dob_valid;
  logic                  clr_req;
  logic                  clr_all;
  logic [BANK_WIDTH-1:0] clr_bank;
  logic                  clr_busy;
  logic                  clr_done;

  modport master (
    output wea, banka, addra, dia,
    output reb, bankb, addrb,
    output clr_req, clr_all, clr_bank,
    input  dob, dob_valid,
    input  clr_busy, clr_done
  );

  modport slave (
    input  wea, banka, addra, dia,
    input  reb, bankb, addrb,
    input  clr_req, clr_all, clr_bank,
    output dob, dob_valid,
    output clr_busy, clr_done
  );
endinterface

// File: rtl/mem_multi_bank_clr.sv
// Banked simple dual-port memory with registered read pipeline,
// read-during-write bypass and a clear sequencer filling banks with DEFAULT_VALUE.
// Ports: clk, reset (async active-high), bus (slave): write
// wea/banka/addra/dia, read reb/bankb/addrb -> dob/dob_valid,
// clear clr_req/clr_all/clr_bank -> clr_busy/clr_done.
module mem_multi_bank_clr #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int NUM_BANKS = 4,
  parameter int OUTPUT_DELAY = 1,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit BYPASS = 1'b1
) (
  input  logic clk,
  input  logic reset,
  mem_multi_bank_clr_if.slave bus
);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_clr_all;
  logic            w_clr_all_nxt;
  logic [BW-1:0]   r_clr_bank;
  logic [BW-1:0]   w_clr_bank_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic            w_busy;
  logic            w_last;

  logic [DATA_WIDTH-1:0] r_mem [NUM_BANKS][DEPTH];
  logic [NUM_BANKS-1:0]  w_clr_we;
  logic [NUM_BANKS-1:0]  w_usr_we;
  logic                  w_usr_ok;
  logic                  w_rd_ok;
  logic                  w_hit_clr;
  logic                  w_hit_usr;
  logic [DATA_WIDTH-1:0] w_arr;
  logic [DATA_WIDTH-1:0] w_rd_data;

  logic                  w_fin_v;
  logic [DATA_WIDTH-1:0] w_fin_d;
  logic                  r_dob_v;
  logic [DATA_WIDTH-1:0] r_dob;

  assign w_busy = (r_state == S_CLEAR);
  assign w_last = w_busy && (r_cnt == AW'(DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_clr_all  <= 1'b1;
      r_clr_bank <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_all  <= w_clr_all_nxt;
      r_clr_bank <= w_clr_bank_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_all_nxt  = r_clr_all;
    w_clr_bank_nxt = r_clr_bank;
    w_cnt_nxt      = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (bus.clr_req) begin
          w_state_nxt    = S_CLEAR;
          w_clr_all_nxt  = bus.clr_all;
          w_clr_bank_nxt = bus.clr_bank;
          w_cnt_nxt      = '0;
        end
      end
      S_CLEAR: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A clr_bank beyond NUM_BANKS matches no bank, so that clear writes nothing.
  assign w_usr_ok = bus.wea && !w_busy
                 && ({1'b0, bus.banka} < (BW + 1)'(NUM_BANKS))
                 && ({1'b0, bus.addra} < (AW + 1)'(DEPTH));

  always_comb begin
    w_clr_we = '0;
    w_usr_we = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_clr_we[b] = w_busy && !reset
                 && (r_clr_all || (r_clr_bank == BW'(b)));
      w_usr_we[b] = w_usr_ok && (bus.banka == BW'(b));
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_clr_we[b]) begin
        r_mem[b][r_cnt] <= DEFAULT_VALUE;
      end else if (w_usr_we[b]) begin
        r_mem[b][bus.addra] <= bus.dia;
      end
    end
  end

  assign w_rd_ok = ({1'b0, bus.bankb} < (BW + 1)'(NUM_BANKS))
                && ({1'b0, bus.addrb} < (AW + 1)'(DEPTH));

  // Bank select by loop keeps the array index free of bankb width issues.
  always_comb begin
    w_arr     = DEFAULT_VALUE;
    w_hit_clr = 1'b0;
    w_hit_usr = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bus.bankb == BW'(b)) begin
        w_arr     = r_mem[b][bus.addrb];
        w_hit_clr = w_clr_we[b] && (r_cnt == bus.addrb);
        w_hit_usr = w_usr_we[b] && (bus.addra == bus.addrb);
      end
    end
  end

  always_comb begin
    w_rd_data = w_arr;
    if (!w_rd_ok) begin
      w_rd_data = DEFAULT_VALUE;
    end else if (BYPASS && w_hit_clr) begin
      w_rd_data = DEFAULT_VALUE;
    end else if (BYPASS && w_hit_usr) begin
      w_rd_data = bus.dia;
    end
  end

  // OUTPUT_DELAY-1 plain stages, then the dob register that holds on bubbles.
  generate
    if (OUTPUT_DELAY <= 1) begin : g_d1
      assign w_fin_v = bus.reb;
      assign w_fin_d = w_rd_data;
    end else begin : g_dn
      localparam int PS = OUTPUT_DELAY - 1;
      logic [PS-1:0]                 r_pv;
      logic [PS-1:0][DATA_WIDTH-1:0] r_pd;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_pv <= '0;
          r_pd <= '0;
        end else begin
          r_pv[0] <= bus.reb;
          r_pd[0] <= w_rd_data;
          for (int i = 1; i < PS; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pd[i] <= r_pd[i-1];
          end
        end
      end

      assign w_fin_v = r_pv[PS-1];
      assign w_fin_d = r_pd[PS-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dob_v <= 1'b0;
      r_dob   <= '0;
    end else begin
      r_dob_v <= w_fin_v;
      if (w_fin_v) begin
        r_dob <= w_fin_d;
      end
    end
  end

  assign bus.dob       = r_dob;
  assign bus.dob_valid = r_dob_v;
  assign bus.clr_busy  = w_busy;
  assign bus.clr_done  = w_last;
endmodule

// File: tb/tb_mem_multi_bank_clr.sv
// Bench for mem_multi_bank_clr: two configurations share one stimulus
// stream and are checked against an array-level reference model.
module tb_mem_multi_bank_clr;
  logic clk;
  logic reset;

  logic        wea;
  logic [1:0]  banka;
  logic [4:0]  addra;
  logic [15:0] dia;
  logic        reb;
  logic [1:0]  bankb;
  logic [4:0]  addrb;
  logic        clr_req;
  logic        clr_all;
  logic [1:0]  clr_bank;

  mem_multi_bank_clr_if #(.DATA_WIDTH(16), .BANK_WIDTH(2), .ADDR_WIDTH(5)) if0 ();
  mem_multi_bank_clr_if #(.DATA_WIDTH(16), .BANK_WIDTH(2), .ADDR_WIDTH(5)) if1 ();

  assign if0.wea = wea;      assign if1.wea = wea;
  assign if0.banka = banka;  assign if1.banka = banka;
  assign if0.addra = addra;  assign if1.addra = addra;
  assign if0.dia = dia;      assign if1.dia = dia;
  assign if0.reb = reb;      assign if1.reb = reb;
  assign if0.bankb = bankb;  assign if1.bankb = bankb;
  assign if0.addrb = addrb;  assign if1.addrb = addrb;
  assign if0.clr_req = clr_req;   assign if1.clr_req = clr_req;
  assign if0.clr_all = clr_all;   assign if1.clr_all = clr_all;
  assign if0.clr_bank = clr_bank; assign if1.clr_bank = clr_bank;

  logic [15:0] o_dob [2];
  logic        o_v [2];
  logic        o_busy [2];
  logic        o_done [2];

  assign o_dob[0] = if0.dob;        assign o_dob[1] = if1.dob;
  assign o_v[0] = if0.dob_valid;    assign o_v[1] = if1.dob_valid;
  assign o_busy[0] = if0.clr_busy;  assign o_busy[1] = if1.clr_busy;
  assign o_done[0] = if0.clr_done;  assign o_done[1] = if1.clr_done;

  mem_multi_bank_clr #(
    .DATA_WIDTH(16), .DEPTH(32), .NUM_BANKS(4), .OUTPUT_DELAY(1),
    .DEFAULT_VALUE(16'h0000), .CLEAR_ON_RESET(1'b1), .BYPASS(1'b1)
  ) u0 (.clk(clk), .reset(reset), .bus(if0));

  mem_multi_bank_clr #(
    .DATA_WIDTH(16), .DEPTH(20), .NUM_BANKS(3), .OUTPUT_DELAY(3),
    .DEFAULT_VALUE(16'h5A5A), .CLEAR_ON_RESET(1'b0), .BYPASS(1'b0)
  ) u1 (.clk(clk), .reset(reset), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          cf_nb  [2] = '{4, 3};
  int          cf_dep [2] = '{32, 20};
  int          cf_od  [2] = '{1, 3};
  bit          cf_byp [2] = '{1'b1, 1'b0};
  bit          cf_cor [2] = '{1'b1, 1'b0};
  logic [15:0] cf_def [2] = '{16'h0000, 16'h5A5A};

  logic [15:0] m_mem [2][4][32];
  bit          m_kn  [2][4][32];
  int          m_left [2];
  int          m_addr [2];
  bit          m_all  [2];
  int          m_bank [2];
  bit          pv [2][4];
  logic [15:0] pd [2][4];
  bit          pk [2][4];
  bit          e_v  [2];
  bit          e_kn [2];
  logic [15:0] e_dob [2];
  int          c_busy [2];
  int          c_done [2];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [1:0]  wb;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [1:0]  rb;
    logic [4:0]  ra;
    bit          c0;
    logic [15:0] x0;
    bit          c1;
    logic [15:0] x1;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input int k,
                     input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  task automatic idle();
    wea = 0; banka = 0; addra = 0; dia = 0;
    reb = 0; bankb = 0; addrb = 0;
    clr_req = 0; clr_all = 0; clr_bank = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      e_dob[k] = 16'h0;
      e_kn[k] = 1'b1;
      e_v[k] = 1'b0;
      m_left[k] = cf_cor[k] ? cf_dep[k] : 0;
      m_addr[k] = 0;
      m_all[k] = 1'b1;
      m_bank[k] = 0;
      for (int i = 0; i < 4; i++) pv[k][i] = 1'b0;
      c_busy[k] = 0;
      c_done[k] = 0;
    end
  endtask

  // One clock cycle: check status, predict, clock, check read data.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      bit          busy;
      bit          ch;
      bit          uh;
      bit          rk;
      logic [15:0] rd;
      int          od;
      busy = (m_left[k] > 0);
      od = cf_od[k];
      chk("busy", k, {15'd0, o_busy[k]}, {15'd0, busy});
      chk("done", k, {15'd0, o_done[k]}, {15'd0, m_left[k] == 1});
      if (o_busy[k]) c_busy[k]++;
      if (o_done[k]) c_done[k]++;
      rd = cf_def[k];
      rk = 1'b1;
      if (reb && int'(bankb) < cf_nb[k] && int'(addrb) < cf_dep[k]) begin
        ch = busy && (m_all[k] || m_bank[k] == int'(bankb))
             && m_addr[k] == int'(addrb);
        uh = wea && !busy && banka == bankb && addra == addrb;
        if (cf_byp[k] && ch) rd = cf_def[k];
        else if (cf_byp[k] && uh) rd = dia;
        else begin
          rd = m_mem[k][bankb][addrb];
          rk = m_kn[k][bankb][addrb];
        end
      end
      pv[k][od-1] = reb;
      pd[k][od-1] = rd;
      pk[k][od-1] = rk;
      e_v[k] = pv[k][0];
      if (pv[k][0]) begin
        e_dob[k] = pd[k][0];
        e_kn[k] = pk[k][0];
      end
      for (int i = 0; i < 3; i++) begin
        pv[k][i] = pv[k][i+1];
        pd[k][i] = pd[k][i+1];
        pk[k][i] = pk[k][i+1];
      end
      pv[k][3] = 1'b0;
      if (busy) begin
        for (int b = 0; b < cf_nb[k]; b++) begin
          if (m_all[k] || m_bank[k] == b) begin
            m_mem[k][b][m_addr[k]] = cf_def[k];
            m_kn[k][b][m_addr[k]] = 1'b1;
          end
        end
        m_addr[k]++;
        m_left[k]--;
      end else if (wea && int'(banka) < cf_nb[k]
                   && int'(addra) < cf_dep[k]) begin
        m_mem[k][banka][addra] = dia;
        m_kn[k][banka][addra] = 1'b1;
      end
      if (!busy && clr_req) begin
        m_left[k] = cf_dep[k];
        m_addr[k] = 0;
        m_all[k] = clr_all;
        m_bank[k] = int'(clr_bank);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("dob_valid", k, {15'd0, o_v[k]}, {15'd0, e_v[k]});
      if (e_kn[k]) chk("dob", k, o_dob[k], e_dob[k]);
    end
  endtask

  task automatic read_all_u0(input string nm, input logic [15:0] v_lo,
                             input logic [15:0] v_b3);
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 32; a++) begin
        reb = 1; bankb = 2'(b); addrb = 5'(a);
        step();
        chk(nm, 0, o_dob[0], (b == 3) ? v_b3 : v_lo);
      end
    end
    reb = 0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < 32; a++) begin
          m_kn[k][b][a] = 1'b0;
          m_mem[k][b][a] = 16'h0;
        end

    tbl[0]  = '{1'b1, 2'd1, 5'd5,  16'h0042, 1'b0, 2'd0, 5'd0,
                1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 2'd1, 5'd5,  16'h1234, 1'b1, 2'd1, 5'd5,
                1'b1, 16'h1234, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 2'd2, 5'd7,  16'hA5A5, 1'b0, 2'd0, 5'd0,
                1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 2'd0, 5'd0,  16'h0000, 1'b1, 2'd2, 5'd7,
                1'b1, 16'hA5A5, 1'b1, 16'h0042};
    tbl[4]  = '{1'b0, 2'd0, 5'd0,  16'h0000, 1'b1, 2'd3, 5'd0,
                1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[5]  = '{1'b1, 2'd3, 5'd3,  16'hBEEF, 1'b0, 2'd0, 5'd0,
                1'b0, 16'h0000, 1'b1, 16'hA5A5};
    tbl[6]  = '{1'b0, 2'd0, 5'd0,  16'h0000, 1'b1, 2'd3, 5'd3,
                1'b1, 16'hBEEF, 1'b1, 16'h5A5A};
    tbl[7]  = '{1'b1, 2'd0, 5'd25, 16'h7777, 1'b0, 2'd0, 5'd0,
                1'b0, 16'h0000, 1'b1, 16'h5A5A};
    tbl[8]  = '{1'b0, 2'd0, 5'd0,  16'h0000, 1'b1, 2'd0, 5'd25,
                1'b1, 16'h7777, 1'b1, 16'h5A5A};
    tbl[9]  = '{1'b0, 2'd0, 5'd0,  16'h0000, 1'b1, 2'd1, 5'd5,
                1'b1, 16'h1234, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 2'd0, 5'd0,  16'h0000, 1'b0, 2'd0, 5'd0,
                1'b0, 16'h0000, 1'b1, 16'h5A5A};
    tbl[11] = '{1'b0, 2'd0, 5'd0,  16'h0000, 1'b0, 2'd0, 5'd0,
                1'b0, 16'h0000, 1'b1, 16'h1234};

    // Reset and power-on clear; u1 gets an explicit all-bank clear.
    idle();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_dob", k, o_dob[k], 16'h0);
      chk("rst_valid", k, {15'd0, o_v[k]}, 16'h0);
      chk("rst_busy", k, {15'd0, o_busy[k]}, {15'd0, cf_cor[k]});
      chk("rst_done", k, {15'd0, o_done[k]}, 16'h0);
    end
    model_reset();
    reset = 0;
    clr_req = 1; clr_all = 1;
    step();
    idle();
    repeat (40) step();
    chk("init_busy_len", 0, 16'(c_busy[0]), 16'd32);
    chk("init_done_cnt", 0, 16'(c_done[0]), 16'd1);
    chk("clr_busy_len", 1, 16'(c_busy[1]), 16'd20);
    chk("clr_done_cnt", 1, 16'(c_done[1]), 16'd1);
    read_all_u0("init_read", 16'h0000, 16'h0000);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      wea = tbl[i].we; banka = tbl[i].wb; addra = tbl[i].wa;
      dia = tbl[i].wd; reb = tbl[i].re; bankb = tbl[i].rb;
      addrb = tbl[i].ra;
      step();
      if (tbl[i].c0) chk($sformatf("tbl%0d", i), 0, o_dob[0], tbl[i].x0);
      if (tbl[i].c1) chk($sformatf("tbl%0d", i), 1, o_dob[1], tbl[i].x1);
    end
    idle();

    // Fill everything, then clear bank 3 only.
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 32; a++) begin
        wea = 1; banka = 2'(b); addra = 5'(a); dia = 16'hFFFF;
        step();
      end
    idle();
    clr_req = 1; clr_all = 0; clr_bank = 2'd3;
    c_busy = '{0, 0}; c_done = '{0, 0};
    step();
    wea = 1; banka = 0; addra = 0; dia = 16'h1111;
    clr_req = 1; clr_all = 1;
    step();
    idle();
    repeat (40) step();
    chk("bank_busy_len", 0, 16'(c_busy[0]), 16'd32);
    chk("bank_done_cnt", 0, 16'(c_done[0]), 16'd1);
    chk("bad_bank_busy_len", 1, 16'(c_busy[1]), 16'd20);
    read_all_u0("bank3_read", 16'hFFFF, 16'h0000);

    // Random traffic with occasional clears and forced collisions.
    for (int i = 0; i < 1500; i++) begin
      wea = 1'($urandom);
      banka = 2'($urandom);
      addra = 5'($urandom);
      dia = 16'($urandom);
      reb = 1'($urandom);
      if ($urandom_range(2) == 0) begin
        bankb = banka; addrb = addra;
      end else begin
        bankb = 2'($urandom); addrb = 5'($urandom);
      end
      clr_req = ($urandom_range(63) == 0);
      clr_all = 1'($urandom);
      clr_bank = 2'($urandom);
      step();
    end
    idle();

    // Reset in the middle of a clear.
    for (int i = 0; i < 40 && (o_busy[0] || o_busy[1]); i++) step();
    chk("drain", 0, {15'd0, o_busy[0]}, 16'h0);
    clr_req = 1; clr_all = 1;
    step();
    idle();
    repeat (10) step();
    reset = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("abort_busy", k, {15'd0, o_busy[k]}, {15'd0, cf_cor[k]});
      chk("abort_valid", k, {15'd0, o_v[k]}, 16'h0);
      chk("abort_dob", k, o_dob[k], 16'h0);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    repeat (40) step();
    chk("restart_busy_len", 0, 16'(c_busy[0]), 16'd32);
    chk("restart_done_cnt", 0, 16'(c_done[0]), 16'd1);
    chk("noclr_busy_len", 1, 16'(c_busy[1]), 16'd0);
    read_all_u0("restart_read", 16'h0000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
